// File: rtl/maxpool_engine.sv
// Sequential max-pooling engine: latches a frame, then walks each pooling
// window one kernel element per cycle and presents per-channel maxima with
// a valid/ready handshake.
module maxpool_engine #(
  parameter int unsigned DATAI_WIDTH   = 4,
  parameter int unsigned DATAI_HEIGHT  = 4,
  parameter int unsigned KERNEL_WIDTH  = 2,
  parameter int unsigned KERNEL_HEIGHT = 2,
  parameter int unsigned STRIDE        = 2,
  parameter int unsigned PADDING       = 0,
  parameter int unsigned CHANNELS      = 1,
  parameter int unsigned BITWIDTH      = 3,
  parameter int unsigned SIGNED_EN     = 0
) (
  input  logic                                               clk_en,
  input  logic                                               reset,
  input  logic                                               start,
  input  logic [CHANNELS*DATAI_HEIGHT*DATAI_WIDTH*BITWIDTH-1:0] data_i,
  input  logic                                               ready_i,
  output logic                                               valid_o,
  output logic [CHANNELS*BITWIDTH-1:0]                       data_o,
  output logic [3:0]                                         out_row,
  output logic [3:0]                                         out_col,
  output logic                                               busy,
  output logic                                               done
);

  localparam int unsigned FRAME_W      = CHANNELS * DATAI_HEIGHT * DATAI_WIDTH * BITWIDTH;
  localparam int unsigned IDX_W        = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int unsigned DATAO_WIDTH  = (DATAI_WIDTH - KERNEL_WIDTH + 2 * PADDING) / STRIDE + 1;
  localparam int unsigned DATAO_HEIGHT = (DATAI_HEIGHT - KERNEL_HEIGHT + 2 * PADDING) / STRIDE + 1;
  localparam int unsigned KR_W         = (KERNEL_HEIGHT > 1) ? $clog2(KERNEL_HEIGHT) : 1;
  localparam int unsigned KC_W         = (KERNEL_WIDTH > 1) ? $clog2(KERNEL_WIDTH) : 1;
  localparam int unsigned OUT_W        = CHANNELS * BITWIDTH;

  // Border pixels must never beat a real pixel: 0 unsigned, most-negative signed.
  localparam logic [BITWIDTH-1:0] PAD_VAL =
    (SIGNED_EN != 0) ? (BITWIDTH'(1) << (BITWIDTH - 1)) : '0;

  typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

  state_t              state_q, state_d;
  logic [FRAME_W-1:0]  frame_q;
  logic [KR_W-1:0]     kr_q;
  logic [KC_W-1:0]     kc_q;
  logic [OUT_W-1:0]    acc_q, acc_d;
  logic                first_elem, last_elem, last_col_elem, last_win, last_out_col;
  int                  row_i, col_i;
  logic                in_frame;

  function automatic logic is_greater(input logic [BITWIDTH-1:0] a, input logic [BITWIDTH-1:0] b);
    if (SIGNED_EN != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  assign first_elem    = (kr_q == '0) && (kc_q == '0);
  assign last_col_elem = (kc_q == KC_W'(KERNEL_WIDTH - 1));
  assign last_elem     = last_col_elem && (kr_q == KR_W'(KERNEL_HEIGHT - 1));
  assign last_out_col  = (out_col == 4'(DATAO_WIDTH - 1));
  assign last_win      = last_out_col && (out_row == 4'(DATAO_HEIGHT - 1));

  // Frame coordinate of the kernel element visited this cycle.
  always_comb begin
    row_i    = int'(out_row) * int'(STRIDE) + int'(kr_q) - int'(PADDING);
    col_i    = int'(out_col) * int'(STRIDE) + int'(kc_q) - int'(PADDING);
    in_frame = (row_i >= 0) && (row_i < int'(DATAI_HEIGHT)) &&
               (col_i >= 0) && (col_i < int'(DATAI_WIDTH));
  end

  for (genvar ch = 0; ch < int'(CHANNELS); ch++) begin : g_ch
    int                  base;
    logic [BITWIDTH-1:0] pix, cur, nxt;

    // Fetch this channel's pixel and fold it into the running maximum.
    always_comb begin
      base = ((ch * int'(DATAI_HEIGHT) + row_i) * int'(DATAI_WIDTH) + col_i) * int'(BITWIDTH);
      if (!in_frame) base = 0;
      pix = frame_q[IDX_W'(base) +: BITWIDTH];
      if (!in_frame) pix = PAD_VAL;
      cur = acc_q[ch*BITWIDTH +: BITWIDTH];
      nxt = cur;
      if (first_elem || is_greater(pix, cur)) nxt = pix;
    end

    assign acc_d[ch*BITWIDTH +: BITWIDTH] = nxt;
  end

  // State register.
  always_ff @(posedge clk_en or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (last_elem) state_d = OUT;
      OUT:     if (ready_i) state_d = last_win ? IDLE : SCAN;
      default: state_d = IDLE;
    endcase
  end

  // Frame buffer, kernel/window counters, accumulators and registered outputs.
  always_ff @(posedge clk_en or posedge reset) begin
    if (reset) begin
      frame_q <= '0;
      kr_q    <= '0;
      kc_q    <= '0;
      acc_q   <= '0;
      data_o  <= '0;
      out_row <= '0;
      out_col <= '0;
      valid_o <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            frame_q <= data_i;
            kr_q    <= '0;
            kc_q    <= '0;
            acc_q   <= '0;
            out_row <= '0;
            out_col <= '0;
            busy    <= 1'b1;
          end
        end
        SCAN: begin
          acc_q <= acc_d;
          if (last_elem) begin
            kr_q    <= '0;
            kc_q    <= '0;
            data_o  <= acc_d;
            valid_o <= 1'b1;
          end else if (last_col_elem) begin
            kc_q <= '0;
            kr_q <= kr_q + KR_W'(1);
          end else begin
            kc_q <= kc_q + KC_W'(1);
          end
        end
        OUT: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            if (last_win) begin
              busy <= 1'b0;
              done <= 1'b1;
            end else if (last_out_col) begin
              out_col <= '0;
              out_row <= out_row + 4'd1;
            end else begin
              out_col <= out_col + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_engine.sv
// Directed bench for maxpool_engine: three parameterisations share one
// clock/reset; a selector routes start and observes one instance at a time.
module tb_maxpool_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_g;
  logic        ready_g;
  int          sel;

  logic [47:0] frame_def;
  logic [47:0] data_def;
  logic [11:0] data_sgn;
  logic [95:0] data_ch2;

  logic       v0, v1, v2, b0, b1, b2, dn0, dn1, dn2;
  logic [2:0] d0, d1;
  logic [5:0] d2;
  logic [3:0] r0, r1, r2, c0, c1, c2;

  logic       m_valid, m_busy, m_done;
  logic [5:0] m_data;
  logic [3:0] m_row, m_col;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string           name;
    int              sel;
    int              stall;
    bit              disturb;
    logic [3:0][5:0] d;
  } case_t;

  case_t cases [5];

  maxpool_engine u_def (
    .clk_en(clk), .reset(reset), .start(start_g && (sel == 0)), .data_i(data_def),
    .ready_i(ready_g), .valid_o(v0), .data_o(d0), .out_row(r0), .out_col(c0),
    .busy(b0), .done(dn0)
  );

  maxpool_engine #(.DATAI_WIDTH(2), .DATAI_HEIGHT(2), .PADDING(1), .SIGNED_EN(1)) u_sgn (
    .clk_en(clk), .reset(reset), .start(start_g && (sel == 1)), .data_i(data_sgn),
    .ready_i(ready_g), .valid_o(v1), .data_o(d1), .out_row(r1), .out_col(c1),
    .busy(b1), .done(dn1)
  );

  maxpool_engine #(.CHANNELS(2)) u_ch2 (
    .clk_en(clk), .reset(reset), .start(start_g && (sel == 2)), .data_i(data_ch2),
    .ready_i(ready_g), .valid_o(v2), .data_o(d2), .out_row(r2), .out_col(c2),
    .busy(b2), .done(dn2)
  );

  // Observe the selected instance.
  always_comb begin
    m_valid = v0; m_data = {3'b000, d0}; m_row = r0; m_col = c0; m_busy = b0; m_done = dn0;
    if (sel == 1) begin
      m_valid = v1; m_data = {3'b000, d1}; m_row = r1; m_col = c1; m_busy = b1; m_done = dn1;
    end else if (sel == 2) begin
      m_valid = v2; m_data = d2; m_row = r2; m_col = c2; m_busy = b2; m_done = dn2;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse start for one cycle; returns at the negedge after the accepting edge.
  task automatic start_frame(input bit disturb);
    @(negedge clk);
    data_def = frame_def;
    start_g  = 1'b1;
    @(negedge clk);
    start_g = 1'b0;
    if (disturb) data_def = '1;
  endtask

  // Collect the four windows of a 2x2-output frame and check the end-of-frame pulse.
  task automatic collect(input case_t c, input bit chain);
    int cyc;
    for (int w = 0; w < 4; w++) begin
      cyc = 0;
      while (!m_valid && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      if (!m_valid) begin
        chk($sformatf("%s_timeout_w%0d", c.name, w), 32'(m_valid), 32'd1);
        return;
      end
      chk($sformatf("%s_latency_w%0d", c.name, w), 32'(cyc + 1), 32'd5);
      if (w == 0 && c.stall > 0) begin
        for (int s = 0; s < c.stall; s++) begin
          chk($sformatf("%s_hold%0d", c.name, s), {m_valid, m_data, m_row, m_col},
              {1'b1, c.d[0], 4'd0, 4'd0});
          if (s < c.stall - 1) @(negedge clk);
        end
        ready_g = 1'b1;
      end
      if (c.disturb && w == 1) start_g = 1'b1;
      chk($sformatf("%s_data_w%0d", c.name, w), 32'(m_data), 32'(c.d[w]));
      chk($sformatf("%s_pos_w%0d", c.name, w), {m_row, m_col}, {4'(w / 2), 4'(w % 2)});
      @(negedge clk);
      start_g = 1'b0;
    end
    chk($sformatf("%s_end", c.name), {m_done, m_busy, m_valid}, 3'b100);
    if (chain) start_g = 1'b1;
    @(negedge clk);
    chk($sformatf("%s_done_pulse", c.name), 32'(m_done), 32'd0);
  endtask

  task automatic run_case(input case_t c);
    sel     = c.sel;
    ready_g = (c.stall == 0);
    start_frame(c.disturb);
    collect(c, 1'b0);
    ready_g = 1'b1;
  endtask

  initial begin
    reset   = 1'b1;
    start_g = 1'b0;
    ready_g = 1'b1;
    sel     = 0;

    frame_def = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        frame_def = frame_def | (48'((r % 2) * 4 + c) << ((r * 4 + c) * 3));
    data_def = frame_def;
    data_sgn = {4{3'b101}};
    data_ch2 = {{16{3'b010}}, frame_def};

    cases[0] = '{name: "basic",      sel: 0, stall: 0, disturb: 1'b0, d: {6'd7, 6'd5, 6'd7, 6'd5}};
    cases[1] = '{name: "stall",      sel: 0, stall: 6, disturb: 1'b0, d: {6'd7, 6'd5, 6'd7, 6'd5}};
    cases[2] = '{name: "ignore",     sel: 0, stall: 0, disturb: 1'b1, d: {6'd7, 6'd5, 6'd7, 6'd5}};
    cases[3] = '{name: "signed_pad", sel: 1, stall: 0, disturb: 1'b0, d: {6'd5, 6'd5, 6'd5, 6'd5}};
    cases[4] = '{name: "two_ch",     sel: 2, stall: 0, disturb: 1'b0, d: {6'd23, 6'd21, 6'd23, 6'd21}};

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("reset_ctrl", {m_valid, m_busy, m_done}, 3'b000);
    chk("reset_data", {m_data, m_row, m_col}, 14'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(m_busy), 32'd0);

    for (int i = 0; i < 5; i++) run_case(cases[i]);

    // Reset during the second scan cycle of window (0,1), then a clean frame.
    sel = 0;
    ready_g = 1'b1;
    start_frame(1'b0);
    begin
      int cyc = 0;
      while (!m_valid && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      chk("midreset_first_valid", 32'(m_valid), 32'd1);
    end
    @(negedge clk);
    @(negedge clk);
    chk("midreset_pre_col", 32'(m_col), 32'd1);
    reset = 1'b1;
    #1;
    chk("midreset_ctrl", {m_valid, m_busy, m_done}, 3'b000);
    chk("midreset_data", {m_data, m_row, m_col}, 14'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("midreset_no_resume", {m_valid, m_busy}, 2'b00);
    start_frame(1'b0);
    collect(cases[0], 1'b1);

    // Start raised in the done cycle: accepted, and the next frame runs in full.
    start_g = 1'b0;
    chk("chain_busy", 32'(m_busy), 32'd1);
    collect(cases[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maxpool_engine.md
MAXPOOL_ENGINE -- requirements
Module: maxpool_engine

Interface
REQ-001 SHALL have parameter DATAI_WIDTH, default 4, input frame columns.
REQ-002 SHALL have parameter DATAI_HEIGHT, default 4, input frame rows.
REQ-003 SHALL have parameter KERNEL_WIDTH, default 2, window columns.
REQ-004 SHALL have parameter KERNEL_HEIGHT, default 2, window rows.
REQ-005 SHALL have parameter STRIDE, default 2, window step in both axes.
REQ-006 SHALL have parameter PADDING, default 0, border pixels added on each side.
REQ-007 SHALL have parameter CHANNELS, default 1, channels pooled in parallel.
REQ-008 SHALL have parameter BITWIDTH, default 3, element width.
REQ-009 SHALL have parameter SIGNED_EN, default 0; 1 selects two's-complement compare.
REQ-010 SHALL derive DATAO_WIDTH = (DATAI_WIDTH-KERNEL_WIDTH+2*PADDING)/STRIDE+1, and DATAO_HEIGHT likewise from the height parameters.
REQ-011 SHALL have port clk_en  input  1  sole clock, rising edge.
REQ-012 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-013 SHALL have port start  input  1  frame start request.
REQ-014 SHALL have port data_i  input  CHANNELS*DATAI_HEIGHT*DATAI_WIDTH*BITWIDTH  frame; element (ch,r,c) at bit ((ch*DATAI_HEIGHT+r)*DATAI_WIDTH+c)*BITWIDTH.
REQ-015 SHALL have port ready_i  input  1  downstream ready.
REQ-016 SHALL have port valid_o  output  1  result valid.
REQ-017 SHALL have port data_o  output  CHANNELS*BITWIDTH  window maxima; channel ch at bit ch*BITWIDTH.
REQ-018 SHALL have port out_row, out_col  output  4 each  output coordinate of data_o.
REQ-019 SHALL have port busy  output  1  frame in progress.
REQ-020 SHALL have port done  output  1  one-cycle end-of-frame pulse.

Function
REQ-021 SHALL implement states IDLE, SCAN, OUT, with IDLE as the reset state.
REQ-022 IDLE with start=1 SHALL register data_i into an internal frame buffer, clear window/kernel counters, set busy, and enter SCAN next cycle; start in any other state SHALL be ignored.
REQ-023 SCAN SHALL visit one kernel element per cycle in row-major order, KERNEL_WIDTH*KERNEL_HEIGHT cycles per window, keeping a running maximum per channel; the first element SHALL load the accumulator unconditionally.
REQ-024 Element position SHALL be (out_row*STRIDE+kr-PADDING, out_col*STRIDE+kc-PADDING); positions outside the frame SHALL read as 0 when SIGNED_EN=0, or as the most negative value (1 followed by zeros) when SIGNED_EN=1.
REQ-025 Compare SHALL be unsigned when SIGNED_EN=0 and signed when SIGNED_EN=1; no widening, and data_o SHALL be exactly BITWIDTH bits per channel.
REQ-026 After the last kernel element, the state SHALL go to OUT with valid_o=1 and the maxima on data_o.
REQ-027 In OUT, data_o, out_row, out_col and valid_o SHALL hold stable until the cycle in which valid_o and ready_i are both 1.
REQ-028 On handshake, windows SHALL advance in raster order (out_col first, then out_row), and the state SHALL return to SCAN.
REQ-029 On the handshake of window (DATAO_HEIGHT-1, DATAO_WIDTH-1), the next cycle SHALL give valid_o=0, busy=0, and done=1 for one cycle, with the state in IDLE.
REQ-030 start may be asserted in the same cycle as done; it SHALL then be accepted on the following IDLE cycle.
REQ-031 Latency from start acceptance to the first valid_o SHALL be KERNEL_WIDTH*KERNEL_HEIGHT+1 cycles; with ready_i held at 1, each later window SHALL take KERNEL_WIDTH*KERNEL_HEIGHT+1 cycles.
REQ-032 data_i changes while busy SHALL NOT affect results.

Reset
REQ-033 While reset=1, in any state, the block SHALL go to IDLE and drive valid_o=0, busy=0, done=0, data_o=0, out_row=0, out_col=0, with all counters and accumulators cleared.
REQ-034 After reset deasserts, the block SHALL wait for a new start; any frame interrupted by reset SHALL NOT resume.

Verification
REQ-035 Defaults, rows 0..3 = {0,1,2,3},{4,5,6,7},{0,1,2,3},{4,5,6,7}, ready_i=1 -> outputs 5,7,5,7 at (0,0),(0,1),(1,0),(1,1); first valid_o 5 cycles after start; done after the fourth output.
REQ-036 Same frame, ready_i=0 for 6 cycles at the first OUT -> valid_o=1, data_o=5, out_row/out_col=0/0 stable throughout; no skipped or duplicated window.
REQ-037 SIGNED_EN=1, PADDING=1, DATAI 2x2 all 3'b101 (-3), kernel 2, stride 2 -> four outputs, each 3'b101 (padding -4 never wins).
REQ-038 CHANNELS=2, ch0 as REQ-035, ch1 all 3'b010 -> data_o per window = {ch1=2, ch0=5/7/5/7}.
REQ-039 reset asserted in the 2nd SCAN cycle of window (0,1) -> all outputs 0 immediately; a new start then yields the full REQ-035 sequence from (0,0).
REQ-040 start pulsed while busy, and data_i altered mid-frame -> ignored, with REQ-035 outputs unchanged.
